// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD coprocessor: default sizes and engine state encoding.
package gcd_pkg;
    localparam int W_DEF     = 16;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/gcd_if.sv
// Request/response val/rdy bundle between the host (master) and the GCD coprocessor (slave).
interface gcd_if #(parameter int W = 16);
    logic         operands_val;
    logic [W-1:0] operands_bits_A;
    logic [W-1:0] operands_bits_B;
    logic         operands_rdy;
    logic         result_val;
    logic [W-1:0] result_bits;
    logic         result_rdy;

    modport master (
        output operands_val, operands_bits_A, operands_bits_B, result_rdy,
        input  operands_rdy, result_val, result_bits
    );

    modport slave (
        input  operands_val, operands_bits_A, operands_bits_B, result_rdy,
        output operands_rdy, result_val, result_bits
    );
endinterface

// File: rtl/gcd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; dout reads as zero while empty.
module gcd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A push into a full FIFO is legal when the same cycle pops the head.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/gcd_coprocessor.sv
// GCD coprocessor: request FIFO -> subtract/swap Euclid engine -> response FIFO.
//  state | meaning
//  IDLE  | waiting for a buffered operand pair
//  CALC  | one swap or subtract step per cycle until regB is zero
//  DONE  | regA holds the GCD; waiting for room in the response FIFO
module gcd_coprocessor
    import gcd_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic  clk,
    input  logic  reset,
    gcd_if.slave  io
);
    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   w_a_next;
    logic [W-1:0]   w_b_next;

    logic           w_req_push;
    logic           w_req_pop;
    logic           w_req_full;
    logic           w_req_empty;
    logic [2*W-1:0] w_req_dout;

    logic           w_resp_push;
    logic           w_resp_pop;
    logic           w_resp_full;
    logic           w_resp_empty;
    logic [W-1:0]   w_resp_dout;

    assign io.operands_rdy = !w_req_full;
    assign w_req_push      = io.operands_val && !w_req_full;
    assign io.result_val   = !w_resp_empty;
    assign io.result_bits  = w_resp_dout;
    assign w_resp_pop      = !w_resp_empty && io.result_rdy;

    gcd_fifo #(.WIDTH(2*W), .DEPTH(DEPTH)) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_req_push),
        .i_din   ({io.operands_bits_A, io.operands_bits_B}),
        .i_pop   (w_req_pop),
        .o_full  (w_req_full),
        .o_empty (w_req_empty),
        .o_dout  (w_req_dout)
    );

    gcd_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_resp_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_resp_push),
        .i_din   (r_a),
        .i_pop   (w_resp_pop),
        .o_full  (w_resp_full),
        .o_empty (w_resp_empty),
        .o_dout  (w_resp_dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_req_pop    = 1'b0;
        w_resp_push  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_req_empty) begin
                    w_req_pop    = 1'b1;
                    w_a_next     = w_req_dout[2*W-1:W];
                    w_b_next     = w_req_dout[W-1:0];
                    w_state_next = CALC;
                end
            end
            CALC: begin
                // Swapping first keeps regA >= regB, so the subtract cannot underflow.
                if (r_a < r_b) begin
                    w_a_next = r_b;
                    w_b_next = r_a;
                end else if (r_b != '0) begin
                    w_a_next = r_a - r_b;
                end else begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (!w_resp_full) begin
                    w_resp_push  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_gcd_coprocessor.sv
// Scoreboard bench for gcd_coprocessor: expected GCDs queued on accept, compared on result.
module tb_gcd_coprocessor;
    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    gcd_if #(.W(W)) u_if ();

    gcd_coprocessor #(.W(W), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .io    (u_if)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_resp  = 0;
    logic [W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Result handshake is sampled mid-cycle; the transfer completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && u_if.result_val && u_if.result_rdy) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", u_if.result_bits, 'x);
            end else begin
                check($sformatf("result%0d", n_resp), u_if.result_bits, exp_q.pop_front());
            end
            n_resp++;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int budget;
        budget = 0;
        u_if.operands_val    = 1'b1;
        u_if.operands_bits_A = a;
        u_if.operands_bits_B = b;
        @(negedge clk);
        while (!u_if.operands_rdy && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (u_if.operands_rdy) exp_q.push_back(gcd_ref(a, b));
        else check("send_rdy_timeout", W'(u_if.operands_rdy), W'(1));
        @(posedge clk);
        #1;
        if (!hold) u_if.operands_val = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check({"drain_", tag}, W'(exp_q.size()), W'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy"},  W'(u_if.operands_rdy), W'(1));
        check({tag, "_val"},  W'(u_if.result_val),   W'(0));
        check({tag, "_bits"}, u_if.result_bits,      W'(0));
    endtask

    logic [W-1:0] singles [7][2] = '{'{7, 7}, '{12, 8}, '{200, 35}, '{15, 9},
                                     '{99, 36}, '{1, 2}, '{144, 168}};
    logic [W-1:0] corners [5][2] = '{'{0, 0}, '{5, 0}, '{0, 9}, '{40, 40}, '{65535, 1}};

    initial begin
        u_if.operands_val    = 1'b0;
        u_if.operands_bits_A = '0;
        u_if.operands_bits_B = '0;
        u_if.result_rdy      = 1'b1;
        reset                = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("after_reset");

        foreach (singles[i]) begin
            send(singles[i][0], singles[i][1], 1'b0);
            @(posedge clk);
            #1;
        end
        wait_drain("singles", 5000);

        foreach (corners[i]) begin
            send(corners[i][0], corners[i][1], 1'b0);
            @(posedge clk);
            #1;
        end
        wait_drain("corners", 70000);

        for (int i = 0; i < 8; i++) begin
            send(W'($urandom_range(255, 0)), W'($urandom_range(255, 1)), 1'b0);
        end
        wait_drain("random", 10000);

        u_if.result_rdy = 1'b0;
        for (int i = 0; i < 2*DEPTH+1; i++) begin
            send(W'((i+1)*6), W'((i+1)*4), 1'b0);
        end
        repeat (300) @(posedge clk);
        #1;
        check("bp_operands_rdy", W'(u_if.operands_rdy), W'(0));
        check("bp_result_val",   W'(u_if.result_val),   W'(1));
        check("bp_result_head",  u_if.result_bits,      W'(2));
        u_if.result_rdy = 1'b1;
        wait_drain("backpressure", 5000);

        for (int i = 0; i < 6; i++) begin
            send(W'(30 + i*7), W'(12 + i), 1'b1);
        end
        u_if.operands_val = 1'b0;
        wait_drain("back_to_back", 5000);

        send(W'(250), W'(190), 1'b0);
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_idle_outputs("post_mid_reset");
        send(W'(5), W'(250), 1'b0);
        wait_drain("after_reset", 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end
endmodule
